// File: rtl/shifter_iter.sv
// shifter_iter: multi-cycle 16-bit shift/rotate unit.
//
// The shift is built from four power-of-two stages (8, 4, 2, 1), one per clock.
// An accepted operation always spends exactly four cycles in RUN, even when cnt is 0.
// An invalid op skips RUN and goes straight to DONE with err set.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request; accepted on a rising edge when not busy
//   in     - 16-bit operand, captured on acceptance
//   op     - 000 rol, 001 ror, 010 sll, 011 sra, 100 srl; 101-111 invalid
//   cnt    - shift amount 0-15, captured on acceptance
//   busy   - high while the shift is running
//   done   - one-cycle pulse when out/err become valid
//   err    - set with done for an invalid op; held until the next acceptance
//   out    - result register; held until the next done
module shifter_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [2:0]  op,
    input  logic [3:0]  cnt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] out
);

    localparam logic [2:0] OpRol = 3'b000;
    localparam logic [2:0] OpRor = 3'b001;
    localparam logic [2:0] OpSll = 3'b010;
    localparam logic [2:0] OpSra = 3'b011;
    localparam logic [2:0] OpSrl = 3'b100;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] work_q, work_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] out_q, out_d;
    logic        err_q, err_d;

    logic [4:0]  amt;
    logic [15:0] staged;
    logic [15:0] next_work;

    // One stage of the shifter; k is always 1, 2, 4 or 8 here.
    function automatic logic [15:0] stage(input logic [15:0] w, input logic [2:0] o,
                                          input logic [4:0] k);
        logic [15:0] r;
        r = w;
        case (o)
            OpRol:   r = (w << k) | (w >> (5'd16 - k));
            OpRor:   r = (w >> k) | (w << (5'd16 - k));
            OpSll:   r = w << k;
            OpSra:   r = 16'($signed(w) >>> k);
            OpSrl:   r = w >> k;
            default: r = w;
        endcase
        return r;
    endfunction

    // step 3 -> 8, step 2 -> 4, step 1 -> 2, step 0 -> 1
    assign amt       = 5'd1 << step_q;
    assign staged    = stage(work_q, op_q, amt);
    assign next_work = cnt_q[step_q] ? staged : work_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        work_d  = work_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = err_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    work_d = in;
                    op_d   = op;
                    cnt_d  = cnt;
                    err_d  = 1'b0;
                    if (op <= OpSrl) begin
                        state_d = StRun;
                        step_d  = 2'd3;
                    end else begin
                        // Invalid op: pass the operand through and flag it.
                        state_d = StDone;
                        out_d   = in;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                work_d = next_work;
                if (step_q == 2'd0) begin
                    out_d   = next_work;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    step_d = step_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            work_q  <= 16'h0000;
            op_q    <= 3'b000;
            cnt_q   <= 4'd0;
            out_q   <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            work_q  <= work_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign err  = err_q;
    assign out  = out_q;

endmodule
